// File: rtl/lvds_rx_pkg.sv
// Shared encodings for the dual-channel LVDS sample scheduler.
// No logic of its own.
// No backpressure.
package lvds_rx_pkg;

    typedef enum logic [1:0] {
        SCHED_IDLE  = 2'b00,
        SCHED_RUN   = 2'b01,
        SCHED_DRAIN = 2'b11
    } sched_state_e;

    localparam logic CH_09 = 1'b0;
    localparam logic CH_24 = 1'b1;

    localparam int OVF_CNT_W = 16;

endpackage

// File: rtl/lvds_rx_chan_buf.sv
// One receive channel: word buffer, drop statistics and link-lock watchdog.
// Latency: a buffered word is poppable the cycle after its push.
// Backpressure: none upstream; a push into a full buffer with no pop is dropped and counted.
module lvds_rx_chan_buf
    import lvds_rx_pkg::*;
#(
    parameter int BUF_DEPTH    = 2,
    parameter int LOCK_WORDS   = 4,
    parameter int LOCK_TIMEOUT = 40
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 push_raw,
    input  logic                 accept,
    input  logic [31:0]          push_dat,
    input  logic                 pop,
    input  logic                 clear_stats,
    output logic                 empty,
    output logic [31:0]          rd_dat,
    output logic                 locked,
    output logic                 overflow,
    output logic [OVF_CNT_W-1:0] ovf_count
);

    localparam int GAP_W = $clog2(LOCK_TIMEOUT + 1);
    localparam int OT_W  = $clog2(LOCK_WORDS + 1);
    localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(LOCK_TIMEOUT);
    localparam logic [OT_W-1:0]  OT_MAX  = OT_W'(LOCK_WORDS);

    logic                 full;
    logic                 drop;
    logic [OVF_CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;
    logic                 ovf_flag_q, ovf_flag_d;
    logic [GAP_W-1:0]     gap_q, gap_d;
    logic [OT_W-1:0]      ontime_q, ontime_d;

    lvds_rx_fifo #(
        .W     (32),
        .DEPTH (BUF_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_vld (accept),
        .wr_dat (push_dat),
        .rd_rdy (pop),
        .rd_dat (rd_dat),
        .full   (full),
        .empty  (empty)
    );

    assign drop = accept && full && !pop;

    // Clear is applied first so a coincident drop lands on a zeroed counter.
    always_comb begin
        ovf_cnt_d  = ovf_cnt_q;
        ovf_flag_d = ovf_flag_q;
        if (clear_stats) begin
            ovf_cnt_d  = '0;
            ovf_flag_d = 1'b0;
        end
        if (drop) begin
            ovf_flag_d = 1'b1;
            if (ovf_cnt_d != '1) begin
                ovf_cnt_d = ovf_cnt_d + OVF_CNT_W'(1);
            end
        end
    end

    // Lock follows raw input pushes, so buffer drops never affect it.
    always_comb begin
        gap_d    = gap_q;
        ontime_d = ontime_q;
        if (push_raw) begin
            gap_d = '0;
        end else if (gap_q != GAP_MAX) begin
            gap_d = gap_q + GAP_W'(1);
        end
        if (!enable || (gap_d == GAP_MAX)) begin
            ontime_d = '0;
        end else if (push_raw && (gap_q < GAP_MAX) && (ontime_q != OT_MAX)) begin
            ontime_d = ontime_q + OT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_cnt_q  <= '0;
            ovf_flag_q <= 1'b0;
            gap_q      <= '0;
            ontime_q   <= '0;
        end else begin
            ovf_cnt_q  <= ovf_cnt_d;
            ovf_flag_q <= ovf_flag_d;
            gap_q      <= gap_d;
            ontime_q   <= ontime_d;
        end
    end

    assign locked    = (ontime_q == OT_MAX);
    assign overflow  = ovf_flag_q;
    assign ovf_count = ovf_cnt_q;

endmodule

// File: rtl/lvds_rx_fifo.sv
// Small synchronous FIFO with first-word fall-through read data.
// Latency: a write is visible on rd_dat the cycle after it is accepted.
// Backpressure: a write into a full FIFO is accepted only if a read happens that cycle.
module lvds_rx_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr_vld,
    input  logic [W-1:0] wr_dat,
    input  logic         rd_rdy,
    output logic [W-1:0] rd_dat,
    output logic         full,
    output logic         empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          wr_en, rd_en;

    assign empty  = (cnt_q == '0);
    assign full   = (cnt_q == (AW+1)'(DEPTH));
    assign rd_en  = rd_rdy && !empty;
    assign wr_en  = wr_vld && (!full || rd_en);
    assign rd_dat = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (wr_en) begin
            mem_d[wr_ptr_q] = wr_dat;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (wr_en && !rd_en) begin
            cnt_d = cnt_q + (AW+1)'(1);
        end else if (!wr_en && rd_en) begin
            cnt_d = cnt_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/lvds_rx_sched.sv
// Round-robin scheduler merging the sub-GHz and 2.4 GHz sample streams into one FIFO port.
// Latency: 2 cycles from input push to o_fifo_push when the buffer is empty and FIFO not full.
// Backpressure: i_fifo_full stalls all pops; per-channel buffers absorb, then drop and count.
module lvds_rx_sched
    import lvds_rx_pkg::*;
#(
    parameter int BUF_DEPTH    = 2,
    parameter int LOCK_WORDS   = 4,
    parameter int LOCK_TIMEOUT = 40,
    parameter int TAG_CHANNEL  = 1
) (
    input  logic        i_ddr_clk,
    input  logic        i_rst_b,
    input  logic [1:0]  i_ch_enable,
    input  logic        i_ch0_push,
    input  logic [31:0] i_ch0_data,
    input  logic        i_ch1_push,
    input  logic [31:0] i_ch1_data,
    input  logic        i_fifo_full,
    input  logic        i_clear_stats,
    output logic        o_fifo_push,
    output logic [31:0] o_fifo_data,
    output logic [1:0]  o_ch_locked,
    output logic [1:0]  o_overflow,
    output logic [15:0] o_ch0_ovf_count,
    output logic [15:0] o_ch1_ovf_count,
    output logic [1:0]  o_state
);

    sched_state_e state_q, state_d;
    logic         rr_last_q, rr_last_d;
    logic         fifo_push_q, fifo_push_d;
    logic [31:0]  fifo_data_q, fifo_data_d;

    logic [1:0]   push_raw;
    logic [1:0]   accept;
    logic [1:0]   empty;
    logic [1:0]   pop;
    logic         sel;
    logic [31:0]  ch0_rd_dat, ch1_rd_dat;
    logic [31:0]  word;
    logic [31:0]  out_word;

    assign push_raw = {i_ch1_push, i_ch0_push};
    assign accept   = push_raw & i_ch_enable & {2{state_q == SCHED_RUN}};

    lvds_rx_chan_buf #(
        .BUF_DEPTH    (BUF_DEPTH),
        .LOCK_WORDS   (LOCK_WORDS),
        .LOCK_TIMEOUT (LOCK_TIMEOUT)
    ) u_ch0 (
        .clk         (i_ddr_clk),
        .rst_n       (i_rst_b),
        .enable      (i_ch_enable[0]),
        .push_raw    (push_raw[0]),
        .accept      (accept[0]),
        .push_dat    (i_ch0_data),
        .pop         (pop[0]),
        .clear_stats (i_clear_stats),
        .empty       (empty[0]),
        .rd_dat      (ch0_rd_dat),
        .locked      (o_ch_locked[0]),
        .overflow    (o_overflow[0]),
        .ovf_count   (o_ch0_ovf_count)
    );

    lvds_rx_chan_buf #(
        .BUF_DEPTH    (BUF_DEPTH),
        .LOCK_WORDS   (LOCK_WORDS),
        .LOCK_TIMEOUT (LOCK_TIMEOUT)
    ) u_ch1 (
        .clk         (i_ddr_clk),
        .rst_n       (i_rst_b),
        .enable      (i_ch_enable[1]),
        .push_raw    (push_raw[1]),
        .accept      (accept[1]),
        .push_dat    (i_ch1_data),
        .pop         (pop[1]),
        .clear_stats (i_clear_stats),
        .empty       (empty[1]),
        .rd_dat      (ch1_rd_dat),
        .locked      (o_ch_locked[1]),
        .overflow    (o_overflow[1]),
        .ovf_count   (o_ch1_ovf_count)
    );

    // The pointer only moves on contested pops; uncontested pops leave fairness untouched.
    always_comb begin
        pop       = 2'b00;
        sel       = CH_09;
        rr_last_d = rr_last_q;
        if (!i_fifo_full && !(&empty)) begin
            if (!empty[0] && !empty[1]) begin
                sel       = ~rr_last_q;
                rr_last_d = ~rr_last_q;
            end else if (!empty[1]) begin
                sel = CH_24;
            end else begin
                sel = CH_09;
            end
            pop[sel] = 1'b1;
        end
    end

    assign word     = (sel == CH_24) ? ch1_rd_dat : ch0_rd_dat;
    assign out_word = (TAG_CHANNEL != 0) ? {sel, word[30:0]} : word;

    always_comb begin
        fifo_push_d = |pop;
        fifo_data_d = (|pop) ? out_word : fifo_data_q;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            SCHED_IDLE: begin
                if (|i_ch_enable) state_d = SCHED_RUN;
            end
            SCHED_RUN: begin
                if (i_ch_enable == 2'b00) state_d = (&empty) ? SCHED_IDLE : SCHED_DRAIN;
            end
            SCHED_DRAIN: begin
                if (|i_ch_enable)  state_d = SCHED_RUN;
                else if (&empty)   state_d = SCHED_IDLE;
            end
            default: state_d = SCHED_IDLE;
        endcase
    end

    // rr_last resets to ch1 so the first contested pop goes to ch0.
    always_ff @(posedge i_ddr_clk or negedge i_rst_b) begin
        if (!i_rst_b) begin
            state_q     <= SCHED_IDLE;
            rr_last_q   <= CH_24;
            fifo_push_q <= 1'b0;
            fifo_data_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_last_q   <= rr_last_d;
            fifo_push_q <= fifo_push_d;
            fifo_data_q <= fifo_data_d;
        end
    end

    assign o_fifo_push = fifo_push_q;
    assign o_fifo_data = fifo_data_q;
    assign o_state     = state_q;

endmodule

// File: tb/tb_lvds_rx_sched.sv
// Directed, table-driven bench for lvds_rx_sched with hand-computed expectations.
module tb_lvds_rx_sched;

    logic        clk;
    logic        rst_b;
    logic [1:0]  en;
    logic        p0, p1;
    logic [31:0] d0, d1;
    logic        full;
    logic        clr;
    logic        o_push;
    logic [31:0] o_data;
    logic [1:0]  o_locked;
    logic [1:0]  o_ovf;
    logic [15:0] o_cnt0, o_cnt1;
    logic [1:0]  o_state;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [1:0]  en;
        logic        p0;
        logic [31:0] d0;
        logic        p1;
        logic [31:0] d1;
        logic        full;
        logic        exp_push;
        logic [31:0] exp_data;
        logic [1:0]  exp_ovf;
        logic [15:0] exp_cnt0;
    } vec_t;

    vec_t vq[$];

    lvds_rx_sched dut (
        .i_ddr_clk       (clk),
        .i_rst_b         (rst_b),
        .i_ch_enable     (en),
        .i_ch0_push      (p0),
        .i_ch0_data      (d0),
        .i_ch1_push      (p1),
        .i_ch1_data      (d1),
        .i_fifo_full     (full),
        .i_clear_stats   (clr),
        .o_fifo_push     (o_push),
        .o_fifo_data     (o_data),
        .o_ch_locked     (o_locked),
        .o_overflow      (o_ovf),
        .o_ch0_ovf_count (o_cnt0),
        .o_ch1_ovf_count (o_cnt1),
        .o_state         (o_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic [1:0] v_en, input logic v_p0, input logic [31:0] v_d0,
                           input logic v_p1, input logic [31:0] v_d1, input logic v_full,
                           input logic e_push, input logic [31:0] e_data,
                           input logic [1:0] e_ovf, input logic [15:0] e_cnt0);
        vec_t v;
        v.en = v_en; v.p0 = v_p0; v.d0 = v_d0; v.p1 = v_p1; v.d1 = v_d1; v.full = v_full;
        v.exp_push = e_push; v.exp_data = e_data; v.exp_ovf = e_ovf; v.exp_cnt0 = e_cnt0;
        vq.push_back(v);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_push"},   {31'd0, o_push}, 32'd0);
        chk({tag, "_data"},   o_data, 32'd0);
        chk({tag, "_locked"}, {30'd0, o_locked}, 32'd0);
        chk({tag, "_ovf"},    {30'd0, o_ovf}, 32'd0);
        chk({tag, "_cnt0"},   {16'd0, o_cnt0}, 32'd0);
        chk({tag, "_cnt1"},   {16'd0, o_cnt1}, 32'd0);
        chk({tag, "_state"},  {30'd0, o_state}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_b = 1'b0; en = 2'b00; p0 = 1'b0; p1 = 1'b0;
        d0 = '0; d1 = '0; full = 1'b0; clr = 1'b0;
        #22;
        chk_reset_vals("reset");
        rst_b = 1'b1;

        // Single channel: 2-cycle latency, tag clears bit 31, lock after 4th word.
        en = 2'b01;
        tick();
        chk("run_state", {30'd0, o_state}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            p0 = 1'b1; d0 = 32'h8000_1234;
            tick();
            p0 = 1'b0;
            chk("t1_push_lat1", {31'd0, o_push}, 32'd0);
            chk("t1_lock", {31'd0, o_locked[0]}, (k >= 3) ? 32'd1 : 32'd0);
            tick();
            chk("t1_push_lat2", {31'd0, o_push}, 32'd1);
            chk("t1_data", o_data, 32'h0000_1234);
            tick();
            chk("t1_push_one", {31'd0, o_push}, 32'd0);
            chk("t1_data_hold", o_data, 32'h0000_1234);
            repeat (13) tick();
        end

        // Collisions, round-robin, backpressure, drop and push-on-full-with-pop.
        add_vec(2'b11, 1, 32'hAAAA_0001, 1, 32'h5555_0002, 0, 0, 32'h0000_1234, 2'b00, 16'd0);
        add_vec(2'b11, 0, 32'h0,         0, 32'h0,         0, 1, 32'h2AAA_0001, 2'b00, 16'd0);
        add_vec(2'b11, 0, 32'h0,         0, 32'h0,         0, 1, 32'hD555_0002, 2'b00, 16'd0);
        add_vec(2'b11, 1, 32'hAAAA_0003, 1, 32'h5555_0004, 0, 0, 32'hD555_0002, 2'b00, 16'd0);
        add_vec(2'b11, 0, 32'h0,         0, 32'h0,         0, 1, 32'hD555_0004, 2'b00, 16'd0);
        add_vec(2'b11, 0, 32'h0,         0, 32'h0,         0, 1, 32'h2AAA_0003, 2'b00, 16'd0);
        add_vec(2'b11, 0, 32'h0,         0, 32'h0,         0, 0, 32'h2AAA_0003, 2'b00, 16'd0);
        add_vec(2'b11, 1, 32'h0000_0011, 0, 32'h0,         1, 0, 32'h2AAA_0003, 2'b00, 16'd0);
        add_vec(2'b11, 1, 32'h0000_0022, 0, 32'h0,         1, 0, 32'h2AAA_0003, 2'b00, 16'd0);
        add_vec(2'b11, 1, 32'h0000_0033, 0, 32'h0,         1, 0, 32'h2AAA_0003, 2'b01, 16'd1);
        add_vec(2'b11, 0, 32'h0,         0, 32'h0,         0, 1, 32'h0000_0011, 2'b01, 16'd1);
        add_vec(2'b11, 0, 32'h0,         0, 32'h0,         0, 1, 32'h0000_0022, 2'b01, 16'd1);
        add_vec(2'b11, 0, 32'h0,         0, 32'h0,         0, 0, 32'h0000_0022, 2'b01, 16'd1);
        add_vec(2'b11, 1, 32'h0000_0044, 0, 32'h0,         1, 0, 32'h0000_0022, 2'b01, 16'd1);
        add_vec(2'b11, 1, 32'h0000_0055, 0, 32'h0,         1, 0, 32'h0000_0022, 2'b01, 16'd1);
        add_vec(2'b11, 1, 32'h0000_0066, 0, 32'h0,         0, 1, 32'h0000_0044, 2'b01, 16'd1);
        add_vec(2'b11, 0, 32'h0,         0, 32'h0,         0, 1, 32'h0000_0055, 2'b01, 16'd1);
        add_vec(2'b11, 0, 32'h0,         0, 32'h0,         0, 1, 32'h0000_0066, 2'b01, 16'd1);
        add_vec(2'b11, 0, 32'h0,         0, 32'h0,         0, 0, 32'h0000_0066, 2'b01, 16'd1);
        for (int i = 0; i < vq.size(); i++) begin
            en = vq[i].en; p0 = vq[i].p0; d0 = vq[i].d0;
            p1 = vq[i].p1; d1 = vq[i].d1; full = vq[i].full;
            tick();
            chk($sformatf("vec%0d_push", i), {31'd0, o_push}, {31'd0, vq[i].exp_push});
            chk($sformatf("vec%0d_data", i), o_data, vq[i].exp_data);
            chk($sformatf("vec%0d_ovf", i), {30'd0, o_ovf}, {30'd0, vq[i].exp_ovf});
            chk($sformatf("vec%0d_cnt0", i), {16'd0, o_cnt0}, {16'd0, vq[i].exp_cnt0});
        end
        p0 = 1'b0; p1 = 1'b0; full = 1'b0;

        // ch1 lock, loss on the 40th idle cycle, then relock.
        for (int k = 0; k < 5; k++) begin
            p1 = 1'b1; d1 = 32'h0000_0100;
            tick();
            p1 = 1'b0;
            if (k < 4) repeat (15) tick();
        end
        chk("t4_locked", {31'd0, o_locked[1]}, 32'd1);
        repeat (39) tick();
        chk("t4_hold_39", {31'd0, o_locked[1]}, 32'd1);
        tick();
        chk("t4_lost_40", {31'd0, o_locked[1]}, 32'd0);
        for (int k = 0; k < 5; k++) begin
            p1 = 1'b1;
            tick();
            p1 = 1'b0;
            chk($sformatf("t4_relock%0d", k), {31'd0, o_locked[1]}, (k == 4) ? 32'd1 : 32'd0);
            repeat (15) tick();
        end

        // Drain on disable; pushes during DRAIN are ignored.
        en = 2'b11; full = 1'b1;
        p0 = 1'b1; d0 = 32'h0000_0A01; tick();
        d0 = 32'h0000_0A02; tick();
        p0 = 1'b0; en = 2'b00;
        tick();
        chk("t5_drain_state", {30'd0, o_state}, 32'd3);
        p0 = 1'b1; d0 = 32'h0000_0A03;
        tick();
        p0 = 1'b0;
        chk("t5_ignored_cnt", {16'd0, o_cnt0}, 32'd1);
        full = 1'b0;
        tick();
        chk("t5_out1_push", {31'd0, o_push}, 32'd1);
        chk("t5_out1_data", o_data, 32'h0000_0A01);
        tick();
        chk("t5_out2_data", o_data, 32'h0000_0A02);
        chk("t5_out2_state", {30'd0, o_state}, 32'd3);
        tick();
        chk("t5_no_third", {31'd0, o_push}, 32'd0);
        chk("t5_idle_state", {30'd0, o_state}, 32'd0);

        // Clear coincident with a drop, then plain clear.
        en = 2'b01;
        tick();
        full = 1'b1; p0 = 1'b1;
        d0 = 32'h0000_0B01; tick();
        d0 = 32'h0000_0B02; tick();
        d0 = 32'h0000_0B03; tick();
        chk("t6_cnt_before", {16'd0, o_cnt0}, 32'd2);
        d0 = 32'h0000_0B04; clr = 1'b1;
        tick();
        p0 = 1'b0; clr = 1'b0;
        chk("t6_clr_drop_cnt", {16'd0, o_cnt0}, 32'd1);
        chk("t6_clr_drop_flag", {30'd0, o_ovf}, 32'd1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("t6_clr_cnt", {16'd0, o_cnt0}, 32'd0);
        chk("t6_clr_flag", {30'd0, o_ovf}, 32'd0);

        // Async reset with two words buffered: they must be discarded.
        rst_b = 1'b0;
        #1;
        chk_reset_vals("arst");
        tick();
        full = 1'b0;
        #2;
        rst_b = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("post_rst_push%0d", k), {31'd0, o_push}, 32'd0);
        end
        chk("post_rst_data", o_data, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/lvds_rx_sched.md
Name: lvds_rx_sched

Overview:
- Schedules two lvds_rx sample streams (ch0 = sub-GHz RXD09, ch1 = 2.4 GHz RXD24) onto the single shared sample FIFO write port.
- Both streams share one LVDS DDR clock. Each stream enters a small per-channel buffer; a round-robin arbiter pops words into the FIFO.
- Also provides per-channel enable gating, drain-on-disable, link-lock detection and overflow statistics for the SPI register file.

Parameters:
- BUF_DEPTH, 2, words of buffering per channel (power of 2, ≥2).
- LOCK_WORDS, 4, consecutive on-time words needed to declare lock.
- LOCK_TIMEOUT, 40, cycles without a push before lock is lost (nominal word period is 16 cycles).
- TAG_CHANNEL, 1, when 1, bit 31 of each output word is replaced with the channel id.

Ports:
- i_ddr_clk  in  1  LVDS DDR clock; the only clock.
- i_rst_b  in  1  asynchronous active-low reset.
- i_ch_enable  in  2  per-channel enable; bit n = channel n.
- i_ch0_push  in  1  ch0 word strobe.
- i_ch0_data  in  32  ch0 IQ word.
- i_ch1_push  in  1  ch1 word strobe.
- i_ch1_data  in  32  ch1 IQ word.
- i_fifo_full  in  1  shared FIFO full.
- i_clear_stats  in  1  one-cycle pulse; clears overflow counters and sticky flags.
- o_fifo_push  out  1  FIFO write strobe.
- o_fifo_data  out  32  FIFO write data.
- o_ch_locked  out  2  per-channel lock status.
- o_overflow  out  2  sticky per-channel drop flag.
- o_ch0_ovf_count  out  16  saturating ch0 drop count.
- o_ch1_ovf_count  out  16  saturating ch1 drop count.
- o_state  out  2  scheduler state, for debug.

Behaviour:
- Reset values: o_fifo_push=0, o_fifo_data=0, o_ch_locked=0, o_overflow=0, both counters=0, buffers empty, state IDLE, round-robin pointer favours ch0.
- Scheduler states: IDLE=2'b00, RUN=2'b01, DRAIN=2'b11.
  - IDLE -> RUN when i_ch_enable != 0.
  - RUN -> DRAIN when i_ch_enable == 0 and any buffer is non-empty.
  - RUN -> IDLE when i_ch_enable == 0 and both buffers are empty.
  - DRAIN -> RUN if any enable reasserts.
  - DRAIN -> IDLE when both buffers are empty.
- Accept rule: a chN push is written to bufN only when state is RUN and i_ch_enable[n]=1. Otherwise it is ignored silently; this is not an overflow.
- Overflow: an accepted push that finds bufN full while no pop of bufN occurs in the same cycle is dropped.
  - On a drop: the counter increments, saturating at 16'hFFFF, and o_overflow[n] is set.
  - Push into a full buffer in the same cycle as a pop of that buffer is accepted with no drop.
- Arbiter, evaluated every cycle:
  - If i_fifo_full=0 and at least one buffer is non-empty, pop exactly one word.
  - With one buffer non-empty, pop that buffer.
  - With both non-empty, pop the channel not served last, then update the pointer.
  - If i_fifo_full=1, pop nothing and leave the pointer unchanged.
- Output timing:
  - o_fifo_push and o_fifo_data are registered, 1 cycle after the pop decision. o_fifo_push is high for exactly one cycle per word.
  - o_fifo_data holds its value when no push occurs.
  - Push-to-output latency into an empty buffer with FIFO not full is 2 cycles (buffer write, pop, register).
- Tagging: TAG_CHANNEL=1 gives o_fifo_data = {chan_id, word[30:0]}; TAG_CHANNEL=0 passes the word unchanged.
- Buffers are FIFO-ordered per channel; no reordering within a channel.
- Lock detection, per channel:
  - Gap counter resets to 0 on each chN push and saturates at LOCK_TIMEOUT.
  - An on-time word is a push arriving with gap < LOCK_TIMEOUT. An on-time-word counter counts these, saturating at LOCK_WORDS.
  - o_ch_locked[n] sets when the on-time-word count reaches LOCK_WORDS.
  - Lock and the on-time-word count clear when the gap reaches LOCK_TIMEOUT or when i_ch_enable[n]=0.
  - Lock tracks input pushes, independent of buffer drops.
- i_clear_stats clears counters and sticky flags. A drop in the same cycle as the clear leaves the counter at 1 and the flag set.
- Disabling a channel does not flush its buffer. Buffered words still drain.
- Asynchronous reset mid-transfer discards buffered words immediately. No partial push is emitted.

Decomposition:
- Package lvds_rx_pkg holds:
  - state encodings SCHED_IDLE, SCHED_RUN, SCHED_DRAIN;
  - channel ids CH_09=1'b0, CH_24=1'b1;
  - OVF_CNT_W=16.
- Sub-module lvds_rx_chan_buf is instantiated twice. It contains the BUF_DEPTH buffer, the drop counter, the sticky flag and the lock watchdog.
- Arbiter and scheduler FSM stay in the top module.

Test Plan:
- Enable=2'b01; ch0 pushes every 16 cycles with data 32'h8000_1234; fifo not full -> o_fifo_push 2 cycles after each push, data 32'h0000_1234 (tag 0); o_ch_locked[0]=1 after 4th word.
- Enable=2'b11; both channels push the same cycle, ch0=32'hAAAA_0001, ch1=32'h5555_0002 -> consecutive outputs 32'h2AAA_0001 then 32'hD555_0002; next collision serves ch1 first.
- Hold i_fifo_full=1; ch0 pushes 3 words -> no output, third word dropped, o_ch0_ovf_count=1, o_overflow=2'b01; release full -> first 2 words emerge in order.
- ch1 locked, then pushes stop for 40 cycles -> o_ch_locked[1] falls on the 40th idle cycle; resuming needs 4 more on-time words.
- Two words buffered, enable dropped to 0 -> o_state=DRAIN, both words output, then IDLE; pushes during DRAIN are ignored and the counter stays unchanged.
- i_clear_stats coincident with a drop -> counter=1, flag=1; assert i_rst_b=0 with words buffered -> no push after reset release; all outputs at reset values.
